// File: rtl/regwrite_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regwrite_pkg
// Brief   : Shared state encoding and default widths for the register-write
//           stage of the two-phase pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package regwrite_pkg;

    localparam int c_DEF_DATA_WIDTH  = 32;
    localparam int c_DEF_ADDR_WIDTH  = 5;
    localparam int c_DEF_SYNC_STAGES = 2;
    localparam int c_COUNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

endpackage : regwrite_pkg
`default_nettype wire

// File: rtl/regwrite_stage_2ph_sync_ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_ff
// Brief   : SYNC_STAGES-deep flop chain for bringing a two-phase level into
//           the clk domain; synchronous active-low reset to 0.
// Revision: 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/regwrite_stage_2ph.sv
`default_nettype none
// ============================================================================
// Module  : regwrite_stage_2ph
// Brief   : Two-phase request -> clk-domain register-file write stage with a
//           two-phase acknowledge, debug read port and write counter.
// Revision: 1.0 - initial release
// ============================================================================
module regwrite_stage_2ph
    import regwrite_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = c_DEF_ADDR_WIDTH,
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req,
    output logic                     ack,
    input  logic [ADDR_WIDTH-1:0]    wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic [ADDR_WIDTH-1:0]    dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_rdata,
    output logic [c_COUNT_WIDTH-1:0] wr_count
);

    localparam int c_DEPTH = 2**ADDR_WIDTH;

    logic                     w_req_s;
    logic                     w_pending;
    logic                     w_capture;
    logic                     w_write;
    logic                     w_toggle_ack;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_req_seen;
    logic                     r_ack;
    logic [ADDR_WIDTH-1:0]    r_hold_addr;
    logic [DATA_WIDTH-1:0]    r_hold_data;
    logic [c_COUNT_WIDTH-1:0] r_wr_count;
    logic [DATA_WIDTH-1:0]    r_mem [c_DEPTH];

    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (req),
        .q    (w_req_s)
    );

    assign w_pending = w_req_s ^ r_req_seen;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_write      = 1'b0;
        w_toggle_ack = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pending) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_write     = 1'b1;
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                w_toggle_ack = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bundled data is only sampled on the IDLE->WRITE transition.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_req_seen  <= 1'b0;
            r_ack       <= 1'b0;
            r_hold_addr <= '0;
            r_hold_data <= '0;
            r_wr_count  <= '0;
        end else begin
            if (w_capture) begin
                r_req_seen  <= w_req_s;
                r_hold_addr <= wb_addr;
                r_hold_data <= wb_data;
            end
            if (w_write && (r_hold_addr != '0)) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            if (w_toggle_ack) begin
                r_ack <= ~r_ack;
            end
        end
    end

    // Entry 0 is never written; the read mux also forces it to zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write && (r_hold_addr != '0)) begin
            r_mem[r_hold_addr] <= r_hold_data;
        end
    end

    assign dbg_rdata = (dbg_addr == '0) ? '0 : r_mem[dbg_addr];
    assign ack       = r_ack;
    assign wr_count  = r_wr_count;

endmodule : regwrite_stage_2ph
`default_nettype wire

// File: tb/tb_regwrite_stage_2ph.sv
`default_nettype none
// ============================================================================
// Module  : tb_regwrite_stage_2ph
// Brief   : Directed, table-driven and model-checked random bench for the
//           two-phase register-write stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regwrite_stage_2ph;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic        ack;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_rdata;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;
    int viol_count = 0;

    logic r_prev_req = 1'b0;
    logic r_prev_ack = 1'b0;
    logic r_outstanding = 1'b0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic [15:0] exp_count;
        logic        exp_ack;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] ref_mem [32];
    logic [15:0] ref_count;

    regwrite_stage_2ph #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .ack       (ack),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    // Protocol monitor: a req toggle while the previous one is unacknowledged.
    always @(posedge clk) begin
        r_prev_req <= req;
        r_prev_ack <= ack;
        if (!rstn) begin
            r_outstanding <= 1'b0;
        end else if (req != r_prev_req) begin
            if (r_outstanding && (ack == r_prev_ack)) viol_count <= viol_count + 1;
            r_outstanding <= 1'b1;
        end else if (ack != r_prev_ack) begin
            r_outstanding <= 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    task automatic wait_ack_toggle(input logic prev_ack);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
            if (ack !== prev_ack) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL ack_timeout: ack stayed %0b, required a toggle within 20 cycles", ack);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        logic prev_ack;
        @(negedge clk);
        wb_addr  = a;
        wb_data  = d;
        dbg_addr = a;
        prev_ack = ack;
        req      = ~req;
        wait_ack_toggle(prev_ack);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn = 1'b0;
        req  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        vecs[0] = '{5'd1, 32'h11,       32'h11, 16'd1, 1'b1};
        vecs[1] = '{5'd2, 32'h22,       32'h22, 16'd2, 1'b0};
        vecs[2] = '{5'd3, 32'h33,       32'h33, 16'd3, 1'b1};
        vecs[3] = '{5'd4, 32'h44,       32'h44, 16'd4, 1'b0};
        vecs[4] = '{5'd0, 32'hFFFFFFFF, 32'h0,  16'd4, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_count", {16'd0, wr_count}, 32'd0);
        dbg_addr = 5'd3;
        #1;
        check("reset_r3", dbg_rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single write with edge-exact latency
        @(negedge clk);
        wb_addr = 5'd3;
        wb_data = 32'hDEADBEEF;
        req     = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) check("lat_r3_before_write", dbg_rdata, 32'd0);
            if (e == 4) begin
                check("lat_r3_after_write", dbg_rdata, 32'hDEADBEEF);
                check("lat_ack_e4", {31'd0, ack}, 32'd0);
            end
            if (e == 5) check("lat_ack_e5", {31'd0, ack}, 32'd1);
        end
        check("single_count", {16'd0, wr_count}, 32'd1);

        // Back-to-back handshakes and r0 write
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            do_write(vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_rdata", i), dbg_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_count", i), {16'd0, wr_count}, {16'd0, vecs[i].exp_count});
            check($sformatf("vec%0d_ack", i), {31'd0, ack}, {31'd0, vecs[i].exp_ack});
        end
        for (int i = 1; i <= 4; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("readback_r%0d", i), dbg_rdata, 32'(i * 32'h11));
        end

        // Reset while the FSM is in WRITE, then re-accept with req held high
        reset_dut();
        dbg_addr = 5'd5;
        @(negedge clk);
        wb_addr = 5'd5;
        wb_data = 32'h55;
        req     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_r5", dbg_rdata, 32'd0);
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check("midrst_count", {16'd0, wr_count}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        wait_ack_toggle(1'b0);
        check("rerun_r5", dbg_rdata, 32'h55);
        check("rerun_count", {16'd0, wr_count}, 32'd1);

        // Counter wrap
        reset_dut();
        force dut.r_wr_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_wr_count;
        @(posedge clk);
        #1;
        check("wrap_preload", {16'd0, wr_count}, 32'h0000FFFF);
        do_write(5'd7, 32'hA5A5A5A5);
        check("wrap_count", {16'd0, wr_count}, 32'd0);
        check("wrap_r7", dbg_rdata, 32'hA5A5A5A5);

        // Illegal double toggle must be flagged by the protocol monitor
        reset_dut();
        @(negedge clk);
        req = ~req;
        @(negedge clk);
        req = ~req;
        repeat (4) @(posedge clk);
        #1;
        check("protocol_violation", 32'(viol_count), 32'd1);

        // Legal random traffic against a reference model
        reset_dut();
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        ref_count = '0;
        for (int n = 0; n < 1000; n++) begin
            logic [4:0]  a;
            logic [31:0] d;
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            do_write(a, d);
            if (a != 5'd0) begin
                ref_mem[a] = d;
                ref_count  = ref_count + 16'd1;
            end
            check("rand_rdata", dbg_rdata, ref_mem[a]);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("final_r%0d", i), dbg_rdata, ref_mem[i]);
        end
        check("rand_count", {16'd0, wr_count}, {16'd0, ref_count});
        check("no_legal_violation", 32'(viol_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_regwrite_stage_2ph
`default_nettype wire
